// File: rtl/spi_bridge_pkg.sv
// ---------------------------------------------------------------------------
// spi_bridge_pkg
// Shared definitions for the SPI byte-to-register-bus bridge.
//   state_t          : protocol state machine encoding (S_IDLE .. S_RD_DATA)
//   CMD_WR_BIT       : bit of the command byte that selects write (1) / read (0)
//   TX_TIMEOUT_BYTE  : byte returned to the SPI master when a register read
//                      never completes
//   is_write_cmd()   : decodes the direction bit of a command byte
// ---------------------------------------------------------------------------
package spi_bridge_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_WR_DATA = 3'd2,
        S_RD_WAIT = 3'd3,
        S_RD_DATA = 3'd4
    } state_t;

    localparam int         CMD_WR_BIT      = 7;
    localparam logic [7:0] TX_TIMEOUT_BYTE = 8'hEE;

    function automatic logic is_write_cmd(input logic [7:0] cmd);
        return cmd[CMD_WR_BIT];
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
// Two-flop synchroniser for an asynchronous level, followed by a registered
// copy used to produce single-cycle rise/fall pulses in the sys_clk domain.
// Ports:
//   sys_clk    in  1  system clock
//   sys_rst_n  in  1  asynchronous active-low reset
//   i_async    in  1  asynchronous input level
//   o_sync     out 1  synchronised level
//   o_rise     out 1  1-cycle pulse on a synchronised 0->1 transition
//   o_fall     out 1  1-cycle pulse on a synchronised 1->0 transition
// RESET_VAL is the idle level of the input, so that leaving reset with the
// input at its idle level produces no spurious edge.
// ---------------------------------------------------------------------------
module sync_edge_det #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_reg_bridge.sv
// ---------------------------------------------------------------------------
// spi_reg_bridge
// Protocol layer behind an SPI slave shifter. Each chip-select low period is
// one frame: the first byte is a command (bit 7 = write, bits 6:0 = register
// address), later bytes carry write data or are dummy bytes that clock read
// data out on MISO. Drives a simple register-bus master and supplies the next
// byte the shifter transmits.
// Ports:
//   sys_clk        in  1       system clock (rising edge)
//   sys_rst_n      in  1       asynchronous active-low reset
//   i_cs           in  1       SPI chip select pin, active low, asynchronous
//   i_rx_valid     in  1       pulse: i_rx_data holds a received byte
//   i_rx_data      in  8       received byte
//   o_tx_data      out 8       next byte for the shifter
//   o_reg_addr     out ADDR_W  register address
//   o_reg_wr_en    out 1       write strobe
//   o_reg_wdata    out 8       write data
//   o_reg_rd_en    out 1       read request
//   i_reg_rdata    in  8       read data
//   i_reg_rd_valid in  1       read data valid
//   o_frame_err    out 1       pulse on overrun, read timeout or short frame
//   o_busy         out 1       frame open (synchronised chip select low)
// Build option:
//   SPI_BRIDGE_AUTOINC_EN defined   -> burst mode, address advances after
//                                      every data byte
//   SPI_BRIDGE_AUTOINC_EN undefined -> single-register mode, only the first
//                                      data byte of a frame is acted on
// ---------------------------------------------------------------------------
module spi_reg_bridge
    import spi_bridge_pkg::*;
#(
    parameter int          ADDR_W      = 7,
    parameter logic [7:0]  STATUS_BYTE = 8'hA5,
    parameter logic [15:0] RD_TIMEOUT  = 16'd255
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              i_cs,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    output logic [7:0]        o_tx_data,
    output logic [ADDR_W-1:0] o_reg_addr,
    output logic              o_reg_wr_en,
    output logic [7:0]        o_reg_wdata,
    output logic              o_reg_rd_en,
    input  logic [7:0]        i_reg_rdata,
    input  logic              i_reg_rd_valid,
    output logic              o_frame_err,
    output logic              o_busy
);

`ifdef SPI_BRIDGE_AUTOINC_EN
    localparam logic AUTOINC = 1'b1;
`else
    localparam logic AUTOINC = 1'b0;
`endif

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wr_en;
    logic [7:0]        r_wdata;
    logic              r_rd_en;
    logic              r_frame_err;
    logic [7:0]        r_tx_data;
    logic [15:0]       r_to_cnt;
    logic              r_wr_done;

    logic w_cs_sync;
    logic w_cs_rise;
    logic w_cs_fall;

    logic w_cmd_accept;
    logic w_wr_accept;
    logic w_rd_next;
    logic w_rd_issue;
    logic w_rd_load;
    logic w_timeout;
    logic w_overrun;
    logic w_short;

    // Chip select idles high, so the synchroniser resets to 1.
    sync_edge_det #(
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_async   (i_cs),
        .o_sync    (w_cs_sync),
        .o_rise    (w_cs_rise),
        .o_fall    (w_cs_fall)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A byte arriving together with the chip-select rising edge is still
    // decoded in full; the rising edge only overrides the next state.
    always_comb begin
        w_state_next = r_state;
        w_cmd_accept = 1'b0;
        w_wr_accept  = 1'b0;
        w_rd_next    = 1'b0;
        w_rd_load    = 1'b0;
        w_timeout    = 1'b0;
        w_overrun    = 1'b0;
        w_short      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_cs_fall) begin
                    w_state_next = S_CMD;
                end
            end
            S_CMD: begin
                if (i_rx_valid) begin
                    w_cmd_accept = 1'b1;
                    w_state_next = is_write_cmd(i_rx_data) ? S_WR_DATA : S_RD_WAIT;
                end
            end
            S_WR_DATA: begin
                if (i_rx_valid && !r_wr_done) begin
                    w_wr_accept = 1'b1;
                end
            end
            S_RD_WAIT: begin
                if (i_rx_valid) begin
                    w_overrun = 1'b1;
                end
                if (i_reg_rd_valid) begin
                    w_rd_load    = 1'b1;
                    w_state_next = S_RD_DATA;
                end else if (r_to_cnt == RD_TIMEOUT - 16'd1) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (i_rx_valid && AUTOINC) begin
                    w_rd_next    = 1'b1;
                    w_state_next = S_RD_WAIT;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (w_cs_rise) begin
            if (r_state == S_CMD && !i_rx_valid) begin
                w_short = 1'b1;
            end
            w_state_next = S_IDLE;
        end
    end

    assign w_rd_issue = (w_cmd_accept && !is_write_cmd(i_rx_data)) || w_rd_next;

    // Strobes are registered, so they appear one cycle after the byte that
    // caused them, with the address already updated. The write address
    // advances on the cycle the strobe is visible, i.e. after the write.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_addr      <= '0;
            r_wr_en     <= 1'b0;
            r_wdata     <= 8'h00;
            r_rd_en     <= 1'b0;
            r_frame_err <= 1'b0;
            r_tx_data   <= STATUS_BYTE;
            r_to_cnt    <= 16'd0;
            r_wr_done   <= 1'b0;
        end else begin
            r_wr_en     <= w_wr_accept;
            r_rd_en     <= w_rd_issue;
            r_frame_err <= w_timeout | w_overrun | w_short;

            if (w_wr_accept) begin
                r_wdata <= i_rx_data;
            end

            if (w_cmd_accept) begin
                r_addr <= i_rx_data[ADDR_W-1:0];
            end else if (w_rd_next) begin
                r_addr <= r_addr + 1'b1;
            end else if (AUTOINC && r_wr_en) begin
                r_addr <= r_addr + 1'b1;
            end

            if (w_cs_rise || w_cs_fall) begin
                r_tx_data <= STATUS_BYTE;
            end else if (w_rd_load) begin
                r_tx_data <= i_reg_rdata;
            end else if (w_timeout) begin
                r_tx_data <= TX_TIMEOUT_BYTE;
            end

            if (r_state == S_RD_WAIT && w_state_next == S_RD_WAIT) begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end else begin
                r_to_cnt <= 16'd0;
            end

            // In single-register mode further write bytes of the frame are
            // swallowed once the first one has been taken.
            if (r_state == S_IDLE) begin
                r_wr_done <= 1'b0;
            end else if (w_wr_accept && !AUTOINC) begin
                r_wr_done <= 1'b1;
            end
        end
    end

    assign o_tx_data   = r_tx_data;
    assign o_reg_addr  = r_addr;
    assign o_reg_wr_en = r_wr_en;
    assign o_reg_wdata = r_wdata;
    assign o_reg_rd_en = r_rd_en;
    assign o_frame_err = r_frame_err;
    assign o_busy      = ~w_cs_sync;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_bridge
// Self-checking bench for spi_reg_bridge. Acts as SPI shifter (byte pulses,
// chip select) and as register-bus slave (memory with programmable read
// latency). Expected bus transactions and MISO bytes come from a frame-level
// model of the protocol. Honours SPI_BRIDGE_AUTOINC_EN like the design.
// ---------------------------------------------------------------------------
module tb_spi_reg_bridge;

`ifdef SPI_BRIDGE_AUTOINC_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [6:0] addr;
        logic [7:0] data;
    } busEv_t;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [6:0] a0;
        logic [6:0] a1;
    } wrVec_t;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       cs;
    logic       rxValid;
    logic [7:0] rxData;
    logic [7:0] txData;
    logic [6:0] regAddr;
    logic       regWrEn;
    logic [7:0] regWdata;
    logic       regRdEn;
    logic [7:0] regRdata;
    logic       regRdValid;
    logic       frameErr;
    logic       busy;

    int passCount  = 0;
    int checkCount = 0;
    int cycle      = 0;
    int rdLatency  = 3;
    int rdCnt      = 0;
    logic [6:0] rdAddr;

    logic [7:0] slaveMem [128];
    logic [7:0] modelMem [128];
    busEv_t     wrLog [$];
    busEv_t     rdLog [$];
    int         errLog [$];
    busEv_t     expWr [$];
    busEv_t     expRd [$];

    spi_reg_bridge dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .i_cs           (cs),
        .i_rx_valid     (rxValid),
        .i_rx_data      (rxData),
        .o_tx_data      (txData),
        .o_reg_addr     (regAddr),
        .o_reg_wr_en    (regWrEn),
        .o_reg_wdata    (regWdata),
        .o_reg_rd_en    (regRdEn),
        .i_reg_rdata    (regRdata),
        .i_reg_rd_valid (regRdValid),
        .o_frame_err    (frameErr),
        .o_busy         (busy)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cycle++;

    // Register slave and bus monitor, sampled mid-cycle.
    always @(negedge sys_clk) begin
        regRdValid = 1'b0;
        if (!sys_rst_n) begin
            rdCnt = 0;
        end else begin
            if (rdCnt > 0) begin
                rdCnt--;
                if (rdCnt == 0) begin
                    regRdValid = 1'b1;
                    regRdata   = slaveMem[rdAddr];
                end
            end
            if (regRdEn) begin
                rdLog.push_back('{cycle, regAddr, 8'h00});
                if (rdLatency > 0) begin
                    rdCnt  = rdLatency;
                    rdAddr = regAddr;
                end
            end
            if (regWrEn) begin
                wrLog.push_back('{cycle, regAddr, regWdata});
                slaveMem[regAddr] = regWdata;
            end
            if (frameErr) errLog.push_back(cycle);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // One received byte: records the MISO byte shifted out during it.
    task automatic applyStimulus(input logic [7:0] b, input int gap,
                                 output logic [7:0] txSeen, output int rxCyc);
        @(negedge sys_clk);
        txSeen  = txData;
        rxCyc   = cycle;
        rxValid = 1'b1;
        rxData  = b;
        @(negedge sys_clk);
        rxValid = 1'b0;
        repeat (gap) @(negedge sys_clk);
    endtask

    task automatic openFrame();
        @(negedge sys_clk);
        cs = 1'b0;
        repeat (5) @(negedge sys_clk);
    endtask

    task automatic closeFrame();
        @(negedge sys_clk);
        cs = 1'b1;
        repeat (6) @(negedge sys_clk);
    endtask

    task automatic clearLogs();
        wrLog.delete(); rdLog.delete(); errLog.delete();
        expWr.delete(); expRd.delete();
    endtask

    task automatic checkWrites(input string tag);
        checkOutput({tag, "_wrCount"}, wrLog.size(), expWr.size());
        for (int k = 0; k < expWr.size() && k < wrLog.size(); k++) begin
            checkOutput({tag, "_wrAddr"}, wrLog[k].addr, expWr[k].addr);
            checkOutput({tag, "_wrData"}, wrLog[k].data, expWr[k].data);
            checkOutput({tag, "_wrCycle"}, wrLog[k].cyc, expWr[k].cyc);
        end
    endtask

    task automatic checkReads(input string tag);
        checkOutput({tag, "_rdCount"}, rdLog.size(), expRd.size());
        for (int k = 0; k < expRd.size() && k < rdLog.size(); k++) begin
            checkOutput({tag, "_rdAddr"}, rdLog[k].addr, expRd[k].addr);
            checkOutput({tag, "_rdCycle"}, rdLog[k].cyc, expRd[k].cyc);
        end
    endtask

    initial begin
        wrVec_t     wrTable [4];
        logic [7:0] tx;
        logic [7:0] d;
        logic [7:0] cmd;
        int         c0, c1, c2;
        int         isWr, addr, nBytes;

        wrTable[0] = '{8'h85, 8'h11, 8'h22, 7'd5,   7'd6};
        wrTable[1] = '{8'hFF, 8'hAA, 8'hBB, 7'd127, 7'd0};
        wrTable[2] = '{8'h80, 8'h01, 8'h02, 7'd0,   7'd1};
        wrTable[3] = '{8'hC0, 8'h5A, 8'hC3, 7'd64,  7'd65};

        for (int i = 0; i < 128; i++) begin
            d = 8'($urandom);
            slaveMem[i] = d;
            modelMem[i] = d;
        end

        sys_rst_n = 1'b0;
        cs        = 1'b1;
        rxValid   = 1'b0;
        rxData    = 8'h00;
        regRdata  = 8'h00;
        repeat (3) @(negedge sys_clk);
        checkOutput("rst_tx", txData, 8'hA5);
        checkOutput("rst_addr", regAddr, 0);
        checkOutput("rst_wrEn", regWrEn, 0);
        checkOutput("rst_wdata", regWdata, 0);
        checkOutput("rst_rdEn", regRdEn, 0);
        checkOutput("rst_err", frameErr, 0);
        checkOutput("rst_busy", busy, 0);
        sys_rst_n = 1'b1;
        repeat (4) @(negedge sys_clk);

        // Byte with no open frame is ignored.
        clearLogs();
        applyStimulus(8'h85, 4, tx, c0);
        checkOutput("idle_wr", wrLog.size(), 0);
        checkOutput("idle_rd", rdLog.size(), 0);
        checkOutput("idle_err", errLog.size(), 0);

        // Table of write frames (covers burst and address wrap).
        for (int i = 0; i < 4; i++) begin
            clearLogs();
            openFrame();
            checkOutput("tbl_busy", busy, 1);
            applyStimulus(wrTable[i].cmd, 10, tx, c0);
            checkOutput("tbl_cmdTx", tx, 8'hA5);
            applyStimulus(wrTable[i].d0, 10, tx, c1);
            applyStimulus(wrTable[i].d1, 10, tx, c2);
            closeFrame();
            expWr.push_back('{c1 + 1, wrTable[i].a0, wrTable[i].d0});
            modelMem[wrTable[i].a0] = wrTable[i].d0;
            if (BURST) begin
                expWr.push_back('{c2 + 1, wrTable[i].a1, wrTable[i].d1});
                modelMem[wrTable[i].a1] = wrTable[i].d1;
            end
            checkWrites("tbl");
            checkOutput("tbl_err", errLog.size(), 0);
        end

        // Read burst with a 3-cycle register bus.
        clearLogs();
        rdLatency = 3;
        slaveMem[16] = 8'h3C; modelMem[16] = 8'h3C;
        slaveMem[17] = 8'h4D; modelMem[17] = 8'h4D;
        openFrame();
        applyStimulus(8'h10, 12, tx, c0);
        checkOutput("rdb_tx0", tx, 8'hA5);
        applyStimulus(8'h00, 12, tx, c1);
        checkOutput("rdb_tx1", tx, 8'h3C);
        applyStimulus(8'h00, 12, tx, c2);
        checkOutput("rdb_tx2", tx, BURST ? 8'h4D : 8'h3C);
        closeFrame();
        expRd.push_back('{c0 + 1, 7'h10, 8'h00});
        if (BURST) begin
            expRd.push_back('{c1 + 1, 7'h11, 8'h00});
            expRd.push_back('{c2 + 1, 7'h12, 8'h00});
        end
        checkReads("rdb");
        checkOutput("rdb_err", errLog.size(), 0);

        // Read timeout: slave never answers.
        clearLogs();
        rdLatency = 0;
        openFrame();
        applyStimulus(8'h02, 0, tx, c0);
        repeat (260) @(negedge sys_clk);
        checkOutput("to_rdCount", rdLog.size(), 1);
        checkOutput("to_errCount", errLog.size(), 1);
        if (rdLog.size() > 0 && errLog.size() > 0)
            checkOutput("to_delay", errLog[0] - rdLog[0].cyc, 255);
        checkOutput("to_tx", txData, 8'hEE);
        closeFrame();
        checkOutput("to_errAfterClose", errLog.size(), 1);

        // Overrun: dummy byte arrives before the slave answers.
        clearLogs();
        rdLatency = 20;
        slaveMem[3] = 8'h5E; modelMem[3] = 8'h5E;
        openFrame();
        applyStimulus(8'h03, 3, tx, c0);
        applyStimulus(8'h00, 2, tx, c1);
        checkOutput("ovr_errCount", errLog.size(), 1);
        if (errLog.size() > 0) checkOutput("ovr_errCycle", errLog[0], c1 + 1);
        checkOutput("ovr_txHeld", txData, 8'hA5);
        repeat (25) @(negedge sys_clk);
        checkOutput("ovr_txLoaded", txData, 8'h5E);
        closeFrame();

        // Reset mid write burst, then a frame with no byte.
        clearLogs();
        rdLatency = 3;
        openFrame();
        applyStimulus(8'h85, 10, tx, c0);
        applyStimulus(8'h31, 10, tx, c1);
        expWr.push_back('{c1 + 1, 7'd5, 8'h31});
        modelMem[5] = 8'h31;
        @(negedge sys_clk);
        rxValid = 1'b1;
        rxData  = 8'h77;
        #2 sys_rst_n = 1'b0;
        @(negedge sys_clk);
        checkOutput("abt_tx", txData, 8'hA5);
        checkOutput("abt_addr", regAddr, 0);
        checkOutput("abt_wrEn", regWrEn, 0);
        checkOutput("abt_wdata", regWdata, 0);
        checkOutput("abt_rdEn", regRdEn, 0);
        checkOutput("abt_err", frameErr, 0);
        checkOutput("abt_busy", busy, 0);
        rxValid = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (6) @(negedge sys_clk);
        checkOutput("abt_busyAgain", busy, 1);
        checkWrites("abt");
        checkOutput("abt_errBefore", errLog.size(), 0);
        closeFrame();
        checkOutput("abt_shortErr", errLog.size(), 1);

        // Random frames against the frame-level model.
        for (int f = 0; f < 20; f++) begin
            clearLogs();
            isWr      = int'($urandom_range(0, 1));
            addr      = int'($urandom_range(0, 127));
            nBytes    = int'($urandom_range(1, 3));
            rdLatency = int'($urandom_range(1, 8));
            cmd       = {isWr[0], 7'(addr)};
            openFrame();
            applyStimulus(cmd, 12, tx, c0);
            checkOutput("rnd_cmdTx", tx, 8'hA5);
            if (isWr == 1) begin
                for (int k = 0; k < nBytes; k++) begin
                    d = 8'($urandom);
                    applyStimulus(d, 12, tx, c1);
                    if (k == 0 || BURST) begin
                        expWr.push_back('{c1 + 1, 7'((addr + k) % 128), d});
                        modelMem[(addr + k) % 128] = d;
                    end
                end
            end else begin
                expRd.push_back('{c0 + 1, 7'(addr), 8'h00});
                for (int k = 1; k <= nBytes; k++) begin
                    applyStimulus(8'($urandom), 12, tx, c1);
                    checkOutput("rnd_rdTx", tx,
                                BURST ? modelMem[(addr + k - 1) % 128] : modelMem[addr]);
                    if (BURST) expRd.push_back('{c1 + 1, 7'((addr + k) % 128), 8'h00});
                end
            end
            closeFrame();
            checkWrites("rnd");
            checkReads("rnd");
            checkOutput("rnd_err", errLog.size(), 0);
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
